// File: rtl/wave_sequencer.sv
// Burst playback sequencer: paces an external waveform generator and registers the selected sample.
// Optional macro WAVE_SEQ_SCALE_EN enables right-shift attenuation of the output by the latched shift.
module wave_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic [1:0] mode,
  input  logic [7:0] div,
  input  logic [7:0] cycles,
  input  logic [1:0] shift,
  input  logic [7:0] sin_in,
  input  logic [7:0] full_in,
  input  logic [7:0] half_in,
  input  logic       sin_sign,
  output logic       gen_rst,
  output logic       gen_step,
  output logic [7:0] wave_out,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, INIT, RUN, DONE} state_t;

  state_t     state, state_next;
  logic [1:0] mode_q, shift_q;
  logic [7:0] div_q, cycles_q;
  logic [7:0] div_cnt, period_cnt, period_next;
  logic       prev_sign;
  logic       crossing, step_hit;
  logic [7:0] sample_p0, scaled_p0;

  always_comb begin
    crossing    = prev_sign & ~sin_sign;
    period_next = (crossing && period_cnt != 8'hFF) ? period_cnt + 8'd1 : period_cnt;
    step_hit    = (div_cnt == div_q);
  end

  always_comb begin
    state_next = state;
    gen_rst    = rst;
    gen_step   = 1'b0;
    busy       = (state != IDLE);
    done       = 1'b0;
    case (state)
      IDLE: if (start && !stop) state_next = INIT;
      INIT: begin
        gen_rst    = 1'b1;
        state_next = stop ? IDLE : RUN;
      end
      RUN: begin
        gen_step = step_hit & ~rst;
        if (stop) begin
          gen_rst    = 1'b1;
          state_next = IDLE;
        end else if (cycles_q != 8'd0 && period_next == cycles_q) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      mode_q     <= 2'd0;
      shift_q    <= 2'd0;
      div_q      <= 8'd0;
      cycles_q   <= 8'd0;
      div_cnt    <= 8'd0;
      period_cnt <= 8'd0;
      prev_sign  <= 1'b0;
    end else begin
      state <= state_next;
      if (state == IDLE && state_next == INIT) begin
        mode_q   <= mode;
        shift_q  <= shift;
        div_q    <= div;
        cycles_q <= cycles;
      end
      case (state)
        INIT: begin
          div_cnt    <= 8'd0;
          period_cnt <= 8'd0;
          prev_sign  <= 1'b0;
        end
        RUN: begin
          div_cnt    <= step_hit ? 8'd0 : div_cnt + 8'd1;
          period_cnt <= period_next;
          prev_sign  <= sin_sign;
        end
        default: ;
      endcase
    end
  end

  // p0: sample select and optional attenuation
  always_comb begin
    case (mode_q)
      2'd0:    sample_p0 = sin_in;
      2'd1:    sample_p0 = full_in;
      2'd2:    sample_p0 = half_in;
      default: sample_p0 = 8'd0;
    endcase
  end

`ifdef WAVE_SEQ_SCALE_EN
  assign scaled_p0 = sample_p0 >> shift_q;
`else
  logic unused_shift;
  assign unused_shift = ^shift_q;
  assign scaled_p0    = sample_p0;
`endif

  // p1: output register, zero whenever the next cycle is not a RUN cycle
  always_ff @(posedge clk) begin
    if (rst) wave_out <= 8'd0;
    else     wave_out <= (state_next == RUN) ? scaled_p0 : 8'd0;
  end

endmodule

// File: tb/tb_wave_sequencer.sv
// Self-checking bench for wave_sequencer: directed burst scenarios followed by randomized traffic,
// every cycle compared against a burst-level behavioural model.
module tb_wave_sequencer;

  logic       clk = 1'b0;
  logic       rst, start, stop, sin_sign;
  logic [1:0] mode, shift;
  logic [7:0] div, cycles, sin_in, full_in, half_in;
  logic       gen_rst, gen_step, busy, done;
  logic [7:0] wave_out;

  int n_checks = 0;
  int n_fail   = 0;
  int obs_done, obs_rst, obs_step;

  // model: phase 0 idle, 1 init, 2 run, 3 done
  int         m_ph, m_idx, m_cross;
  bit         m_prev;
  logic [7:0] m_wave;
  logic [1:0] l_mode, l_shift;
  logic [7:0] l_div, l_cycles;

  wave_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode), .div(div),
    .cycles(cycles), .shift(shift), .sin_in(sin_in), .full_in(full_in),
    .half_in(half_in), .sin_sign(sin_sign), .gen_rst(gen_rst), .gen_step(gen_step),
    .wave_out(wave_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] pick_sample();
    logic [7:0] s;
    case (l_mode)
      2'd0:    s = sin_in;
      2'd1:    s = full_in;
      2'd2:    s = half_in;
      default: s = 8'd0;
    endcase
`ifdef WAVE_SEQ_SCALE_EN
    s = s >> l_shift;
`endif
    return s;
  endfunction

  task automatic model_advance();
    int nph;
    int sat;
    if (rst) begin
      m_ph = 0; m_wave = 8'd0;
      l_mode = 0; l_shift = 0; l_div = 0; l_cycles = 0;
      return;
    end
    nph = m_ph;
    case (m_ph)
      0: if (start && !stop) begin
        nph = 1;
        l_mode = mode; l_shift = shift; l_div = div; l_cycles = cycles;
      end
      1: if (stop) nph = 0;
         else begin nph = 2; m_idx = 0; m_prev = 0; m_cross = 0; end
      2: if (stop) nph = 0;
         else begin
           if (m_prev && !sin_sign) m_cross++;
           m_prev = sin_sign;
           sat = (m_cross > 255) ? 255 : m_cross;
           if (l_cycles != 0 && sat == int'(l_cycles)) nph = 3;
           else m_idx++;
         end
      default: nph = 0;
    endcase
    m_wave = (nph == 2) ? pick_sample() : 8'd0;
    m_ph = nph;
  endtask

  // inputs are already set; check outputs mid-cycle, then advance model across the edge
  task automatic tick();
    bit exp_step, exp_rst;
    @(negedge clk);
    exp_step = !rst && m_ph == 2 && (m_idx % (int'(l_div) + 1) == int'(l_div));
    exp_rst  = rst || m_ph == 1 || (stop && (m_ph == 1 || m_ph == 2));
    check_val("busy", busy, m_ph != 0);
    check_val("done", done, m_ph == 3);
    check_val("gen_step", gen_step, exp_step);
    check_val("gen_rst", gen_rst, exp_rst);
    check_val("wave_out", wave_out, m_wave);
    obs_done += done;
    obs_rst  += gen_rst;
    obs_step += gen_step;
    model_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    obs_done = 0; obs_rst = 0; obs_step = 0;
  endtask

  initial begin
    rst = 1; start = 0; stop = 0; sin_sign = 0; mode = 0; shift = 0;
    div = 0; cycles = 0; sin_in = 0; full_in = 0; half_in = 0;
    m_ph = 0; m_idx = 0; m_cross = 0; m_prev = 0; m_wave = 0;
    l_mode = 0; l_shift = 0; l_div = 0; l_cycles = 0;
    clear_obs();
    @(posedge clk); #1;
    tick(); tick();
    rst = 0;
    tick();

    // start and stop together in IDLE
    clear_obs();
    start = 1; stop = 1;
    repeat (3) tick();
    start = 0; stop = 0;
    check_val("both_busy", busy, 1'b0);
    check_val("both_gen_rst_cnt", obs_rst, 0);

    // div=3, cycles=2, sine, sign toggling every 6 clocks
    clear_obs();
    div = 3; cycles = 2; mode = 0;
    for (int i = 0; i < 30; i++) begin
      start = (i == 0);
      sin_sign = ((i / 6) % 2) == 0;
      sin_in = 8'(i * 7);
      tick();
    end
    check_val("burst_done_cnt", obs_done, 1);
    check_val("burst_gen_rst_cnt", obs_rst, 1);
    check_val("burst_step_cnt", obs_step, 4);

    // continuous burst, stopped after 500 RUN clocks
    clear_obs();
    div = 0; cycles = 0; start = 1;
    tick(); start = 0;
    tick();
    for (int i = 0; i < 500; i++) begin
      sin_sign = ($urandom_range(0, 3) == 0) ? ~sin_sign : sin_sign;
      sin_in = 8'($urandom);
      tick();
    end
    stop = 1; tick(); stop = 0;
    check_val("cont_busy_after_stop", busy, 1'b0);
    tick();
    check_val("cont_done_cnt", obs_done, 0);
    check_val("cont_gen_rst_cnt", obs_rst, 2);

    // half-rectified selection holds despite mode change mid-burst
    mode = 2; cycles = 0; div = 1; start = 1;
    tick(); start = 0;
    half_in = 8'h40;
    tick(); tick();
    check_val("half_wave", wave_out, 8'h40);
    mode = 0; sin_in = 8'h11;
    tick();
    check_val("half_after_mode_chg", wave_out, 8'h40);
    stop = 1; tick(); stop = 0; tick();

    // attenuation
    mode = 0; shift = 2; sin_in = 8'hC8; start = 1;
    tick(); start = 0;
    tick(); tick();
`ifdef WAVE_SEQ_SCALE_EN
    check_val("scale_wave", wave_out, 8'h32);
`else
    check_val("scale_wave", wave_out, 8'hC8);
`endif
    shift = 0;

    // reset mid-RUN
    repeat (3) tick();
    rst = 1;
    tick();
    check_val("rst_busy", busy, 1'b0);
    check_val("rst_wave", wave_out, 8'h00);
    check_val("rst_gen_rst", gen_rst, 1'b1);
    check_val("rst_gen_step", gen_step, 1'b0);
    rst = 0;
    tick();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      start    = ($urandom_range(0, 3) == 0);
      stop     = ($urandom_range(0, 59) == 0);
      rst      = ($urandom_range(0, 499) == 0);
      mode     = 2'($urandom);
      shift    = 2'($urandom);
      div      = 8'($urandom_range(0, 5));
      cycles   = 8'($urandom_range(0, 3));
      sin_in   = 8'($urandom);
      full_in  = 8'($urandom);
      half_in  = 8'($urandom);
      if ($urandom_range(0, 3) == 0) sin_sign = ~sin_sign;
      tick();
    end
    rst = 0; start = 0; stop = 0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wave_sequencer.md
WAVE_SEQUENCER -- requirements
Module: wave_sequencer

Interface
REQ-001 SHALL have port clk, input, 1 bit: system clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port start, input, 1 bit: request a playback burst; sampled only in IDLE.
REQ-004 SHALL have port stop, input, 1 bit: abort the current burst.
REQ-005 SHALL have port mode, input, 2 bits: waveform select; 0 = sine, 1 = full-rectified, 2 = half-rectified, 3 = mute.
REQ-006 SHALL have port div, input, 8 bits: step-rate divider; one generator step every div+1 clocks.
REQ-007 SHALL have port cycles, input, 8 bits: number of sine periods to play; 0 = continuous.
REQ-008 SHALL have port shift, input, 2 bits: amplitude attenuation, right-shift amount; used only under SCALE_EN.
REQ-009 SHALL have ports sin_in, full_in and half_in, input, 8 bits each: generator samples (sin_in offset-binary).
REQ-010 SHALL have port sin_sign, input, 1 bit: generator internal sine sign bit (1 = negative).
REQ-011 SHALL have port gen_rst, output, 1 bit: synchronous reset to the generator.
REQ-012 SHALL have port gen_step, output, 1 bit: single-cycle advance enable to the generator.
REQ-013 SHALL have port wave_out, output, 8 bits: registered selected sample.
REQ-014 SHALL have port busy, output, 1 bit: high whenever state != IDLE.
REQ-015 SHALL have port done, output, 1 bit: one-cycle pulse on normal burst completion.

Function
REQ-016 SHALL implement FSM IDLE -> INIT -> RUN -> DONE -> IDLE.
REQ-017 SHALL transition IDLE -> INIT when start=1 and stop=0; stop SHALL win when start and stop are both high in IDLE.
REQ-018 SHALL latch mode, div, cycles and shift on the IDLE -> INIT transition; input changes during a burst SHALL be ignored.
REQ-019 SHALL ignore start while busy=1.
REQ-020 SHALL hold gen_rst=1 for exactly the single INIT cycle, clear the divider and period counters there, then enter RUN.
REQ-021 SHALL, in RUN, increment the divider counter each clock and assert gen_step for one cycle when counter == latched div, then wrap the counter to 0; div=0 SHALL give gen_step every clock in RUN.
REQ-022 SHALL count one period per clock in RUN on which the registered previous sin_sign=1 and the current sin_sign=0 (negative-to-non-negative crossing); the previous-sign register SHALL load 0 in INIT.
REQ-023 SHALL, when latched cycles != 0 and the period count reaches cycles, go RUN -> DONE; the period counter SHALL be 8 bits and saturate at 255.
REQ-024 SHALL, with latched cycles = 0, stay in RUN until stop.
REQ-025 SHALL hold done=1 only in the DONE cycle, then return to IDLE.
REQ-026 SHALL, on stop=1 in INIT or RUN, go to IDLE next clock with no done pulse and assert gen_rst for that cycle.
REQ-027 SHALL register wave_out one clock after the sample inputs: mode 0 -> sin_in, 1 -> full_in, 2 -> half_in, 3 -> 8'd0.
REQ-028 SHALL force wave_out = 8'd0 in IDLE, INIT and DONE.
REQ-029 SHALL keep gen_step=0 outside RUN.

Reset
REQ-030 SHALL, on rst=1, set state=IDLE, all counters and latched fields to 0, wave_out=0, gen_step=0, done=0 and busy=0.
REQ-031 SHALL drive gen_rst=1 during rst, including when rst is asserted mid-burst.

Configuration
REQ-032 SHALL use macro WAVE_SEQ_SCALE_EN; when defined, wave_out SHALL equal the selected sample logically right-shifted by the latched shift (0..3), computed before the output register.
REQ-033 SHALL, when WAVE_SEQ_SCALE_EN is undefined, keep the shift port but ignore it, with wave_out equal to the unshifted sample.

Verification
REQ-034 SHALL cover: start=1, div=3, cycles=2, mode=0 -> gen_rst high 1 cycle, gen_step every 4th clock, DONE after 2 sin_sign 1->0 crossings, done pulse of 1 cycle.
REQ-035 SHALL cover: start and stop both high in IDLE -> busy remains 0, gen_rst remains 0.
REQ-036 SHALL cover: cycles=0, RUN for 500 clocks, then stop=1 -> IDLE next clock, gen_rst=1 for 1 cycle, no done pulse.
REQ-037 SHALL cover: mode=2, half_in=8'h40 in RUN -> wave_out=8'h40 one clock later; mode changed to 0 mid-burst -> wave_out still tracks half_in.
REQ-038 SHALL cover: WAVE_SEQ_SCALE_EN defined, shift=2, sin_in=8'hC8 -> wave_out=8'h32; macro undefined -> wave_out=8'hC8.
REQ-039 SHALL cover: rst=1 mid-RUN -> next clock state IDLE, wave_out=0, busy=0, gen_rst=1.
